// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - load kinds, FSM states and legal store byte-enable patterns for data_mem
package dm_pkg;

  typedef logic [2:0] ld_kind_t;
  typedef logic [0:0] dm_state_t;

  localparam ld_kind_t LD_LW  = 3'd0;
  localparam ld_kind_t LD_LH  = 3'd1;
  localparam ld_kind_t LD_LHU = 3'd2;
  localparam ld_kind_t LD_LB  = 3'd3;
  localparam ld_kind_t LD_LBU = 3'd4;

  localparam dm_state_t ST_CLEAR = 1'b0;
  localparam dm_state_t ST_READY = 1'b1;

  localparam int NUM_LEGAL_BE = 7;
  localparam logic [3:0] LEGAL_BE [NUM_LEGAL_BE] = '{
    4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000
  };

  function automatic logic be_legal(input logic [3:0] be);
    be_legal = 1'b0;
    for (int i = 0; i < NUM_LEGAL_BE; i++) begin
      if (be == LEGAL_BE[i]) be_legal = 1'b1;
    end
  endfunction

endpackage

// File: rtl/data_mem_load_ext.sv
// rtl/data_mem_load_ext.sv - selects the addressed byte/halfword of a word and sign/zero-extends it
module load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  ld_type,
  input  logic [1:0]  byte_off,
  output logic [31:0] result
);

  logic [15:0] half;
  logic [7:0]  byt;

  always_comb begin
    half = byte_off[1] ? word[31:16] : word[15:0];
    case (byte_off)
      2'd0:    byt = word[7:0];
      2'd1:    byt = word[15:8];
      2'd2:    byt = word[23:16];
      default: byt = word[31:24];
    endcase
    case (ld_type)
      LD_LW:   result = word;
      LD_LH:   result = {{16{half[15]}}, half};
      LD_LHU:  result = {16'h0000, half};
      LD_LB:   result = {{24{byt[7]}}, byt};
      LD_LBU:  result = {24'h000000, byt};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// rtl/data_mem.sv - byte-enabled MEM-stage data memory with self-clear after reset; DM_ALIGN_CHECK_EN enables alignment faults
module data_mem
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wd,
  input  logic [2:0]  ld_type,
  output logic [31:0] rdata_w,
  output logic        busy,
  output logic        align_fault
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  dm_state_t         state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       word;
  logic [31:0]       ext;
  logic              ready;
  logic              fault;
  logic              do_wr;
  logic              do_rd;
  logic              unused_addr;

  // Upper address bits alias onto the same words.
  assign idx         = addr[ADDR_W+1:2];
  assign unused_addr = &{1'b0, addr[31:ADDR_W+2]};
  assign word        = mem[idx];
  assign ready       = (state == ST_READY);
  assign busy        = ~ready;

`ifdef DM_ALIGN_CHECK_EN
  logic ld_fault;
  logic st_fault;

  always_comb begin
    ld_fault = 1'b0;
    if (re) begin
      case (ld_type)
        LD_LW:         ld_fault = (addr[1:0] != 2'b00);
        LD_LH, LD_LHU: ld_fault = addr[0];
        default:       ld_fault = 1'b0;
      endcase
    end
  end

  assign st_fault = we & ~be_legal(be);
  assign fault    = ready & (ld_fault | st_fault);

  always_ff @(posedge clk) begin
    if (reset) align_fault <= 1'b0;
    else       align_fault <= fault;
  end
`else
  assign fault       = 1'b0;
  assign align_fault = 1'b0;
`endif

  assign do_wr = ready & we & ~fault;
  assign do_rd = ready & re & ~fault;

  load_ext u_load_ext (
    .word     (word),
    .ld_type  (ld_type),
    .byte_off (addr[1:0]),
    .result   (ext)
  );

  // Read sees mem[idx] before this edge's write lands: read-before-write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!ready) begin
        mem[clr_cnt] <= 32'h0000_0000;
      end else if (do_wr) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      rdata_w <= 32'h0000_0000;
    end else begin
      if (!ready) begin
        clr_cnt <= clr_cnt + ADDR_W'(1);
        if (clr_cnt == '1) state <= ST_READY;
      end
      if (do_rd) rdata_w <= ext;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - table-driven check of data_mem clear, byte/half/word access, wrap, collision and alignment
module tb_data_mem;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;

`ifdef DM_ALIGN_CHECK_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [2:0]  lt;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_af;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wd = '0;
  logic [2:0]  ld_type = '0;
  logic [31:0] rdata_w;
  logic        busy;
  logic        align_fault;

  int checks = 0;
  int errors = 0;
  int n;
  vec_t vecs [$];

  data_mem dut (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .re          (re),
    .addr        (addr),
    .be          (be),
    .wd          (wd),
    .ld_type     (ld_type),
    .rdata_w     (rdata_w),
    .busy        (busy),
    .align_fault (align_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic [31:0] a,
                              input logic [3:0] b, input logic [31:0] d, input logic [2:0] t,
                              input logic c, input logic [31:0] e, input logic f);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.be = b; v.wd = d; v.lt = t;
    v.chk = c; v.exp_rd = e; v.exp_af = f;
    return v;
  endfunction

  task automatic idle();
    we = 1'b0; re = 1'b0; addr = '0; be = '0; wd = '0; ld_type = '0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    we = v.we; re = v.re; addr = v.addr; be = v.be; wd = v.wd; ld_type = v.lt;
    @(posedge clk);
    #1;
    if (v.chk) check({tag, " rdata_w"}, rdata_w, v.exp_rd);
    check({tag, " align_fault"}, {31'b0, align_fault}, {31'b0, v.exp_af});
    idle();
  endtask

  task automatic run_vecs(input string grp);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("%s[%0d]", grp, i));
    vecs.delete();
  endtask

  task automatic count_clear(input string name);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, n, 1024);
  endtask

  initial begin
    // Reset: two cycles, then the clear runs.
    @(posedge clk); #1;
    check("reset busy", {31'b0, busy}, 32'd1);
    check("reset rdata_w", rdata_w, 32'h0);
    check("reset align_fault", {31'b0, align_fault}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    count_clear("clear cycles");

    vecs.push_back(mk(0, 1, 32'h0000, 4'h0, 32'h0, LW, 1, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h0FFC, 4'h0, 32'h0, LW, 1, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h0800, 4'h0, 32'h0, LW, 1, 32'h0, 0));
    vecs.push_back(mk(1, 0, 32'h0010, 4'hF, 32'h12345678, LW, 0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 32'h0012, 4'h4, 32'h00AB0000, LW, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h0010, 4'h0, 32'h0, LW,  1, 32'h12AB5678, 0));
    vecs.push_back(mk(0, 1, 32'h0012, 4'h0, 32'h0, LB,  1, 32'hFFFFFFAB, 0));
    vecs.push_back(mk(0, 1, 32'h0012, 4'h0, 32'h0, LBU, 1, 32'h000000AB, 0));
    vecs.push_back(mk(0, 1, 32'h0011, 4'h0, 32'h0, LB,  1, 32'h00000056, 0));
    vecs.push_back(mk(0, 1, 32'h0013, 4'h0, 32'h0, LBU, 1, 32'h00000012, 0));
    vecs.push_back(mk(0, 1, 32'h0010, 4'h0, 32'h0, LB,  1, 32'h00000078, 0));
    vecs.push_back(mk(0, 1, 32'h0010, 4'h0, 32'h0, LH,  1, 32'h00005678, 0));
    vecs.push_back(mk(1, 0, 32'h0022, 4'hC, 32'h80010000, LW, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h0022, 4'h0, 32'h0, LH,  1, 32'hFFFF8001, 0));
    vecs.push_back(mk(0, 1, 32'h0022, 4'h0, 32'h0, LHU, 1, 32'h00008001, 0));
    vecs.push_back(mk(0, 1, 32'h0020, 4'h0, 32'h0, LW,  1, 32'h80010000, 0));
    vecs.push_back(mk(0, 1, 32'h0023, 4'h0, 32'h0, LB,  1, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 1, 32'h0023, 4'h0, 32'h0, LBU, 1, 32'h00000080, 0));
    vecs.push_back(mk(1, 0, 32'h1004, 4'hF, 32'hCAFEF00D, LW, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h0004, 4'h0, 32'h0, LW, 1, 32'hCAFEF00D, 0));
    vecs.push_back(mk(1, 1, 32'h0004, 4'hF, 32'h00000001, LW, 1, 32'hCAFEF00D, 0));
    vecs.push_back(mk(0, 1, 32'h0004, 4'h0, 32'h0, LW, 1, 32'h00000001, 0));
    vecs.push_back(mk(0, 0, 32'h0010, 4'h0, 32'h0, LW, 1, 32'h00000001, 0));
    vecs.push_back(mk(1, 0, 32'h0004, 4'h0, 32'hFFFFFFFF, LW, 1, 32'h00000001, ALIGN_EN));
    vecs.push_back(mk(0, 1, 32'h0004, 4'h0, 32'h0, LW, 1, 32'h00000001, 0));
    vecs.push_back(mk(0, 1, 32'h0010, 4'h0, 32'h0, 3'd7, 1, 32'h00000000, 0));
    run_vecs("main");

    vecs.push_back(mk(0, 1, 32'h0020, 4'h0, 32'h0, LW, 1, 32'h80010000, 0));
`ifdef DM_ALIGN_CHECK_EN
    vecs.push_back(mk(0, 1, 32'h0013, 4'h0, 32'h0, LW, 1, 32'h80010000, 1));
    vecs.push_back(mk(0, 0, 32'h0000, 4'h0, 32'h0, LW, 1, 32'h80010000, 0));
    vecs.push_back(mk(0, 1, 32'h0023, 4'h0, 32'h0, LH, 1, 32'h80010000, 1));
    vecs.push_back(mk(1, 0, 32'h0010, 4'h6, 32'hFFFFFFFF, LW, 0, 32'h0, 1));
    vecs.push_back(mk(0, 1, 32'h0010, 4'h0, 32'h0, LW, 1, 32'h12AB5678, 0));
`else
    vecs.push_back(mk(0, 1, 32'h0013, 4'h0, 32'h0, LW, 1, 32'h12AB5678, 0));
    vecs.push_back(mk(0, 1, 32'h0023, 4'h0, 32'h0, LH, 1, 32'hFFFF8001, 0));
    vecs.push_back(mk(1, 0, 32'h0010, 4'h6, 32'hFFFFFFFF, LW, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h0010, 4'h0, 32'h0, LW, 1, 32'h12FFFF78, 0));
`endif
    vecs.push_back(mk(1, 0, 32'h0FFC, 4'hF, 32'hDEADBEEF, LW, 0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 32'h0800, 4'hF, 32'h0BADF00D, LW, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h0FFC, 4'h0, 32'h0, LW, 1, 32'hDEADBEEF, 0));
    run_vecs("align");

    // Reset from READY, then again partway through the clear.
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("ready reset busy", {31'b0, busy}, 32'd1);
    check("ready reset rdata_w", rdata_w, 32'h0);
    reset = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    check("busy at clear 500", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    count_clear("mid-clear restart cycles");

    vecs.push_back(mk(0, 1, 32'h0FFC, 4'h0, 32'h0, LW, 1, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h0800, 4'h0, 32'h0, LW, 1, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h0010, 4'h0, 32'h0, LW, 1, 32'h0, 0));
    run_vecs("post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
